alarm_trigger: RTL and testbench
================================

# alarm_trigger

Alarm trigger controller: compares the running time of day against the stored alarm time and drives the `z` ring-request level consumed by the song player. It owns arm/disarm, snooze with a bounded snooze count, and an automatic ring timeout. It sits between the timekeeping/alarm-set registers and the song player.

## Interface

**Parameters**
- `CLK_FREQ`, 100_000_000: clock cycles per second. Set to a small value, e.g. 10, in simulation.
- `SNOOZE_MIN`, 9: snooze length in minutes.
- `RING_TIMEOUT_S`, 60: seconds of continuous ringing before the alarm auto-stops.
- `MAX_SNOOZES`, 3: snoozes allowed per alarm event.

**Ports**
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `alarmsw` in 1: alarm enable switch, already synchronous.
- `snooze_btn` in 1: snooze button, synchronous and debounced upstream, level.
- `cur_hour` in 5: current hour, 0–23.
- `cur_min` in 6: current minute, 0–59.
- `cur_sec` in 6: current second, 0–59.
- `alarm_hour` in 5: alarm hour.
- `alarm_min` in 6: alarm minute.
- `z` out 1: ring request to the song player; high only in RINGING.
- `snoozing` out 1: high only in SNOOZE.
- `snooze_cnt` out 2: snoozes used in the current alarm event.

## Operation

- **States:** DISARMED, ARMED, RINGING, SNOOZE.
- **Reset values:**
  - state = DISARMED.
  - `z` = 0, `snoozing` = 0, `snooze_cnt` = 0.
  - All timers and the prescaler are 0.
- **Global override:** `alarmsw` = 0 forces DISARMED from any state on the next edge. This has top priority. It clears `snooze_cnt` and the timers.
- **DISARMED → ARMED** when `alarmsw` = 1.
- **ARMED → RINGING** on match: `cur_hour` == `alarm_hour` && `cur_min` == `alarm_min` && `cur_sec` == 0.
  - The `cur_sec` == 0 condition prevents re-trigger within the same minute after a stop.
  - Arming mid-minute inside the alarm minute does not ring that day.
  - On entry: ring timer is loaded with `RING_TIMEOUT_S`; `snooze_cnt` is cleared.
- **RINGING:**
  - A rising edge on `snooze_btn` with `snooze_cnt` < `MAX_SNOOZES` → SNOOZE. On entry: snooze timer is loaded with `SNOOZE_MIN`*60 and `snooze_cnt` increments.
  - A rising edge with `snooze_cnt` == `MAX_SNOOZES` is ignored.
  - The ring timer decrements on each second tick. On a tick with the ring timer == 1 → ARMED (auto-stop).
- **SNOOZE:**
  - The snooze timer decrements per tick. On a tick with the timer == 1 → RINGING, with the ring timer reloaded.
  - `snooze_btn` and time matches are ignored.
- **Simultaneous events:**
  - `alarmsw` = 0 beats everything.
  - A snooze edge beats a ring-timeout tick in the same cycle.
  - A match while RINGING or SNOOZE is ignored.
- **Widths:**
  - Prescaler: `$clog2(CLK_FREQ)` bits.
  - Snooze timer: `$clog2(SNOOZE_MIN*60+1)` bits.
  - Ring timer: `$clog2(RING_TIMEOUT_S+1)` bits.
  - Timers saturate at 0 and never wrap.

## Timing

- **Second tick:** a one-cycle pulse when the free-running prescaler wraps from `CLK_FREQ`-1 to 0. The first tick comes `CLK_FREQ` cycles after reset release. The prescaler is never cleared by state changes.
- **Timeout/snooze jitter:** the first tick after entry arrives between 1 and `CLK_FREQ` cycles later. Actual duration = (N-1, N] seconds for a loaded value N.
- **Snooze edge detect:** `snooze_btn` is registered once; the edge is `snooze_btn` & ~`snooze_q`. SNOOZE state appears 1 cycle after the edge cycle, i.e. 2 edges after the button rises.
- **Outputs:** all registered, decoded from the state register. `z` rises 1 cycle after the first match cycle and falls 1 cycle after the causing event.
- **Async reset:** asserting `reset` mid-ring drops `z` immediately, without waiting for a clock edge.

## Structure

- **Shared package `alarm_pkg`:**
  - `alarm_state_t` enum: DISARMED, ARMED, RINGING, SNOOZE.
  - Constants `HOUR_W`=5, `MIN_W`=6, `SEC_W`=6.
  - Default `CLK_FREQ`.
- **Sub-module `tick_gen`:** parameterised by `CLK_FREQ`; ports `clk`, `reset`, `tick`. It is reused by timekeeping.
- **Top:** FSM plus the two timers.

## Test plan

All scenarios use `CLK_FREQ`=10, `SNOOZE_MIN`=1, `RING_TIMEOUT_S`=5, `MAX_SNOOZES`=2.

- **Trigger:** alarm 07:30, `alarmsw`=1, drive 07:29:59 → 07:30:00 → `z`=1 one cycle later. Hold 5 ticks → `z`=0, state ARMED.
- **Late arm:** arm during 07:30:05 with alarm 07:30 → `z` stays 0 through 07:31:00.
- **Snooze:** while ringing, pulse `snooze_btn` → `z`=0, `snoozing`=1, `snooze_cnt`=1. After 60 ticks → `z`=1 with a fresh 5 s timeout.
- **Snooze limit:** snooze twice, then pulse a third time → `z` stays 1, `snooze_cnt`=2. Auto-stop after 5 ticks → `snooze_cnt` cleared on the next trigger.
- **Priority:** a snooze edge coincident with the final ring tick → SNOOZE, not ARMED. `alarmsw`=0 during SNOOZE → DISARMED, all outputs 0 next cycle.
- **Reset:** assert `reset` mid-RINGING between clock edges → `z`=0 immediately. After release, state is DISARMED and the first tick arrives exactly 10 cycles later.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm controller and its neighbours.
package alarm_pkg;

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMED    = 2'd1,
        RINGING  = 2'd2,
        SNOOZE   = 2'd3
    } alarm_state_t;

    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;
    localparam int SEC_W  = 6;

    localparam int DEFAULT_CLK_FREQ = 100_000_000;

    // True only at the very first second of the alarm minute, so a stopped
    // alarm cannot fire again later in the same minute.
    function automatic logic isAlarmMatch(
        input logic [HOUR_W-1:0] curHour,
        input logic [MIN_W-1:0]  curMin,
        input logic [SEC_W-1:0]  curSec,
        input logic [HOUR_W-1:0] alarmHour,
        input logic [MIN_W-1:0]  alarmMin
    );
        return (curHour == alarmHour) && (curMin == alarmMin) && (curSec == '0);
    endfunction

endpackage

// File: rtl/alarm_trigger_tick_gen.sv
// One-second tick generator: a free-running prescaler that emits a single
// registered pulse each time it wraps. Also used by the timekeeping block.
module tick_gen
    import alarm_pkg::*;
#(
    parameter int CLK_FREQ = DEFAULT_CLK_FREQ
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [PW-1:0] LAST_COUNT = PW'(CLK_FREQ - 1);

    logic [PW-1:0] r_presc;
    logic          r_tick;

    // Count clocks within the second and flag the wrap one cycle later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc <= '0;
            r_tick  <= 1'b0;
        end else begin
            if (r_presc == LAST_COUNT) begin
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + PW'(1);
            end
            r_tick <= (r_presc == LAST_COUNT);
        end
    end

    assign tick = r_tick;

endmodule

// File: rtl/alarm_trigger.sv
// Alarm trigger controller: arms on the enable switch, rings when the time of
// day reaches the alarm minute, handles a bounded number of snoozes and stops
// ringing on its own after a timeout.
module alarm_trigger
    import alarm_pkg::*;
#(
    parameter int CLK_FREQ       = DEFAULT_CLK_FREQ,
    parameter int SNOOZE_MIN     = 9,
    parameter int RING_TIMEOUT_S = 60,
    parameter int MAX_SNOOZES    = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alarmsw,
    input  logic              snooze_btn,
    input  logic [HOUR_W-1:0] cur_hour,
    input  logic [MIN_W-1:0]  cur_min,
    input  logic [SEC_W-1:0]  cur_sec,
    input  logic [HOUR_W-1:0] alarm_hour,
    input  logic [MIN_W-1:0]  alarm_min,
    output logic              z,
    output logic              snoozing,
    output logic [1:0]        snooze_cnt
);

    localparam int SNOOZE_LOAD = SNOOZE_MIN * 60;
    localparam int SW = $clog2(SNOOZE_LOAD + 1);
    localparam int RW = $clog2(RING_TIMEOUT_S + 1);
    localparam logic [SW-1:0] SNOOZE_INIT = SW'(SNOOZE_LOAD);
    localparam logic [RW-1:0] RING_INIT   = RW'(RING_TIMEOUT_S);
    localparam logic [1:0]    MAX_CNT     = 2'(MAX_SNOOZES);

    alarm_state_t  r_state, w_stateNext;
    logic [RW-1:0] r_ringTimer, w_ringTimerNext;
    logic [SW-1:0] r_snoozeTimer, w_snoozeTimerNext;
    logic [1:0]    r_snoozeCnt, w_snoozeCntNext;
    logic          r_snoozeQ;
    logic          w_snoozeEdge;
    logic          w_match;
    logic          w_tick;

    tick_gen #(
        .CLK_FREQ(CLK_FREQ)
    ) u_tick_gen (
        .clk  (clk),
        .reset(reset),
        .tick (w_tick)
    );

    assign w_snoozeEdge = snooze_btn & ~r_snoozeQ;
    assign w_match      = isAlarmMatch(cur_hour, cur_min, cur_sec, alarm_hour, alarm_min);

    // State, timers, snooze count and the button history all update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= DISARMED;
            r_ringTimer   <= '0;
            r_snoozeTimer <= '0;
            r_snoozeCnt   <= '0;
            r_snoozeQ     <= 1'b0;
        end else begin
            r_state       <= w_stateNext;
            r_ringTimer   <= w_ringTimerNext;
            r_snoozeTimer <= w_snoozeTimerNext;
            r_snoozeCnt   <= w_snoozeCntNext;
            r_snoozeQ     <= snooze_btn;
        end
    end

    // Next-state logic; the enable switch overrides everything, and a snooze
    // press wins over a ring timeout landing in the same cycle.
    always_comb begin
        w_stateNext       = r_state;
        w_ringTimerNext   = r_ringTimer;
        w_snoozeTimerNext = r_snoozeTimer;
        w_snoozeCntNext   = r_snoozeCnt;

        if (!alarmsw) begin
            w_stateNext       = DISARMED;
            w_ringTimerNext   = '0;
            w_snoozeTimerNext = '0;
            w_snoozeCntNext   = '0;
        end else begin
            case (r_state)
                DISARMED: begin
                    w_stateNext = ARMED;
                end
                ARMED: begin
                    if (w_match) begin
                        w_stateNext     = RINGING;
                        w_ringTimerNext = RING_INIT;
                        w_snoozeCntNext = '0;
                    end
                end
                RINGING: begin
                    if (w_snoozeEdge && (r_snoozeCnt < MAX_CNT)) begin
                        w_stateNext       = SNOOZE;
                        w_snoozeTimerNext = SNOOZE_INIT;
                        w_snoozeCntNext   = r_snoozeCnt + 2'd1;
                    end else if (w_tick) begin
                        if (r_ringTimer == RW'(1)) begin
                            w_stateNext     = ARMED;
                            w_ringTimerNext = '0;
                        end else if (r_ringTimer != '0) begin
                            w_ringTimerNext = r_ringTimer - RW'(1);
                        end
                    end
                end
                SNOOZE: begin
                    if (w_tick) begin
                        if (r_snoozeTimer == SW'(1)) begin
                            w_stateNext       = RINGING;
                            w_snoozeTimerNext = '0;
                            w_ringTimerNext   = RING_INIT;
                        end else if (r_snoozeTimer != '0) begin
                            w_snoozeTimerNext = r_snoozeTimer - SW'(1);
                        end
                    end
                end
                default: begin
                    w_stateNext = DISARMED;
                end
            endcase
        end
    end

    assign z          = (r_state == RINGING);
    assign snoozing   = (r_state == SNOOZE);
    assign snooze_cnt = r_snoozeCnt;

endmodule

// File: tb/tb_alarm_trigger.sv
// Testbench for alarm_trigger: directed scenarios plus random traffic, all
// compared every cycle against a seconds-level behavioural model.
module tb_alarm_trigger;

    localparam int CLK_FREQ       = 10;
    localparam int SNOOZE_MIN     = 1;
    localparam int RING_TIMEOUT_S = 5;
    localparam int MAX_SNOOZES    = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       alarmsw = 1'b0;
    logic       snooze_btn = 1'b0;
    logic [4:0] cur_hour = '0;
    logic [5:0] cur_min = '0;
    logic [5:0] cur_sec = '0;
    logic [4:0] alarm_hour = 5'd7;
    logic [5:0] alarm_min = 6'd30;
    logic       z;
    logic       snoozing;
    logic [1:0] snooze_cnt;

    int nCompared = 0;
    int nMismatched = 0;

    // Reference model: alarm enabled flag, ringing/snoozing flags with the
    // seconds remaining, and the seconds boundary derived from elapsed clocks.
    int mCycles;
    bit mEnabled, mRinging, mSnoozing, mBtnPrev;
    int mRingLeft, mSnoozeLeft, mCnt;

    alarm_trigger #(
        .CLK_FREQ      (CLK_FREQ),
        .SNOOZE_MIN    (SNOOZE_MIN),
        .RING_TIMEOUT_S(RING_TIMEOUT_S),
        .MAX_SNOOZES   (MAX_SNOOZES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .alarmsw   (alarmsw),
        .snooze_btn(snooze_btn),
        .cur_hour  (cur_hour),
        .cur_min   (cur_min),
        .cur_sec   (cur_sec),
        .alarm_hour(alarm_hour),
        .alarm_min (alarm_min),
        .z         (z),
        .snoozing  (snoozing),
        .snooze_cnt(snooze_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural model, advanced on the same edges the design sees.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mCycles = 0; mEnabled = 0; mRinging = 0; mSnoozing = 0;
            mBtnPrev = 0; mRingLeft = 0; mSnoozeLeft = 0; mCnt = 0;
        end else begin
            bit secondBoundary, press;
            secondBoundary = (mCycles > 0) && (mCycles % CLK_FREQ == 0);
            press = snooze_btn && !mBtnPrev;
            mBtnPrev = snooze_btn;
            if (!alarmsw) begin
                mEnabled = 0; mRinging = 0; mSnoozing = 0; mCnt = 0;
            end else if (!mEnabled) begin
                mEnabled = 1;
            end else if (mRinging) begin
                if (press && mCnt < MAX_SNOOZES) begin
                    mRinging = 0; mSnoozing = 1;
                    mSnoozeLeft = SNOOZE_MIN * 60;
                    mCnt++;
                end else if (secondBoundary) begin
                    mRingLeft--;
                    if (mRingLeft == 0) mRinging = 0;
                end
            end else if (mSnoozing) begin
                if (secondBoundary) begin
                    mSnoozeLeft--;
                    if (mSnoozeLeft == 0) begin
                        mSnoozing = 0; mRinging = 1; mRingLeft = RING_TIMEOUT_S;
                    end
                end
            end else if (cur_hour == alarm_hour && cur_min == alarm_min && cur_sec == 0) begin
                mRinging = 1; mRingLeft = RING_TIMEOUT_S; mCnt = 0;
            end
            mCycles++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nCompared++;
        if (observed !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic checkModel();
        checkOutput("z", {31'd0, z}, {31'd0, mRinging});
        checkOutput("snoozing", {31'd0, snoozing}, {31'd0, mSnoozing});
        checkOutput("snooze_cnt", {30'd0, snooze_cnt}, mCnt);
    endtask

    // Wait for a falling edge, compare against the model, then drive inputs.
    task automatic applyStimulus(input logic sw, input logic btn, input int h, input int m, input int s);
        @(negedge clk);
        checkModel();
        alarmsw    = sw;
        snooze_btn = btn;
        cur_hour   = 5'(h);
        cur_min    = 6'(m);
        cur_sec    = 6'(s);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            checkModel();
        end
    endtask

    task automatic doTrigger();
        repeat (3) applyStimulus(1, 0, 7, 29, 59);
        applyStimulus(1, 0, 7, 30, 0);
        applyStimulus(1, 0, 7, 30, 1);
        checkOutput("trigger_z", {31'd0, z}, 32'd1);
    endtask

    task automatic pressSnooze();
        applyStimulus(1, 1, 7, 30, 1);
        applyStimulus(1, 1, 7, 30, 1);
        applyStimulus(1, 0, 7, 30, 1);
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        alarmsw = 1'b0;
        snooze_btn = 1'b0;
        @(negedge clk);
        checkOutput("reset_z", {31'd0, z}, 32'd0);
        checkOutput("reset_snoozing", {31'd0, snoozing}, 32'd0);
        checkOutput("reset_cnt", {30'd0, snooze_cnt}, 32'd0);
        reset = 1'b0;
    endtask

    initial begin
        int firstTick;
        bit found;

        $display("[TB] start");
        doReset();

        // Trigger and auto-stop after the ring timeout.
        doTrigger();
        idle(60);
        checkOutput("autostop_z", {31'd0, z}, 32'd0);

        // Arming inside the alarm minute must not ring.
        applyStimulus(0, 0, 7, 30, 5);
        repeat (20) applyStimulus(1, 0, 7, 30, 5);
        repeat (5) applyStimulus(1, 0, 7, 31, 0);
        checkOutput("late_arm_z", {31'd0, z}, 32'd0);

        // Snooze, wait out the snooze, ring again.
        doTrigger();
        pressSnooze();
        checkOutput("snooze_z", {31'd0, z}, 32'd0);
        checkOutput("snooze_flag", {31'd0, snoozing}, 32'd1);
        checkOutput("snooze_cnt1", {30'd0, snooze_cnt}, 32'd1);
        idle(602);
        checkOutput("resume_z", {31'd0, z}, 32'd1);

        // Second snooze uses the last allowance; the third press is ignored.
        pressSnooze();
        checkOutput("snooze_cnt2", {30'd0, snooze_cnt}, 32'd2);
        idle(602);
        checkOutput("resume2_z", {31'd0, z}, 32'd1);
        pressSnooze();
        checkOutput("limit_z", {31'd0, z}, 32'd1);
        checkOutput("limit_cnt", {30'd0, snooze_cnt}, 32'd2);
        idle(60);
        checkOutput("limit_stop_z", {31'd0, z}, 32'd0);
        checkOutput("limit_keep_cnt", {30'd0, snooze_cnt}, 32'd2);
        doTrigger();
        checkOutput("retrigger_cnt", {30'd0, snooze_cnt}, 32'd0);

        // Snooze press in the same cycle as the final ring second.
        found = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            checkModel();
            if (mRinging && mRingLeft == 1 && mCycles > 0 && (mCycles % CLK_FREQ == 0)) begin
                found = 1;
                break;
            end
        end
        checkOutput("prio_window_found", {31'd0, found}, 32'd1);
        snooze_btn = 1'b1;
        applyStimulus(1, 0, 7, 30, 1);
        checkOutput("prio_snoozing", {31'd0, snoozing}, 32'd1);
        checkOutput("prio_z", {31'd0, z}, 32'd0);
        applyStimulus(0, 0, 7, 30, 1);
        applyStimulus(1, 0, 7, 30, 1);
        checkOutput("disarm_z", {31'd0, z}, 32'd0);
        checkOutput("disarm_snoozing", {31'd0, snoozing}, 32'd0);
        checkOutput("disarm_cnt", {30'd0, snooze_cnt}, 32'd0);

        // Asynchronous reset while ringing, then first tick timing.
        doTrigger();
        @(posedge clk);
        #2 reset = 1'b1;
        #1 checkOutput("async_reset_z", {31'd0, z}, 32'd0);
        alarmsw = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        firstTick = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (dut.w_tick) begin
                firstTick = c;
                break;
            end
        end
        checkOutput("first_tick_cycles", firstTick, 32'd10);

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            int r;
            logic sw, btn;
            int h, m, s;
            sw  = ($urandom_range(0, 299) != 0);
            btn = ($urandom_range(0, 19) == 0) ? ~snooze_btn : snooze_btn;
            r = $urandom_range(0, 7);
            if (r == 0) begin
                h = 7; m = 30; s = 0;
            end else if (r < 3) begin
                h = 7; m = 30; s = $urandom_range(1, 59);
            end else begin
                h = $urandom_range(0, 23); m = $urandom_range(0, 59); s = $urandom_range(0, 59);
            end
            applyStimulus(sw, btn, h, m, s);
        end
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
